hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/md_tracker.sv | 26 ++
 rtl/hazard_ctrl.sv | 97 +++++++++
 tb/tb_hazard_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and the forward-select helper for the pipeline hazard unit.
package hazard_pkg;

   localparam logic [1:0] MEMTO_ALU  = 2'b00;
   localparam logic [1:0] MEMTO_LOAD = 2'b01;
   localparam logic [1:0] MEMTO_PC8  = 2'b10;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_W     = 2'd1,
      FWD_ALU_M = 2'd2,
      FWD_PC8_M = 2'd3
   } fwd_sel_e;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   // M beats W; a write to register 0 never matches, so r0 is never forwarded.
   function automatic logic [1:0] fwd_select(
      input logic [4:0] src,
      input logic [4:0] reg_m,
      input logic       we_m,
      input logic [1:0] memto_m,
      input logic [4:0] reg_w,
      input logic       we_w,
      input logic       allow_w
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (we_m && reg_m != 5'd0 && reg_m == src)
         sel = (memto_m == MEMTO_PC8) ? FWD_PC8_M : FWD_ALU_M;
      else if (allow_w && we_w && reg_w != 5'd0 && reg_w == src)
         sel = FWD_W;
      return sel;
   endfunction

endpackage

// File: rtl/md_tracker.sv
// Multiply/divide occupancy counter: busy for MULT_CYCLES or DIV_CYCLES after a start edge.
module md_tracker
   import hazard_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic md_start_E,
   input  logic md_op_E,
   output logic md_busy
);

   logic [3:0] md_cnt_reg;

   // A start while busy simply reloads: the newest operation owns the unit.
   always_ff @(posedge clk) begin
      if (reset)
         md_cnt_reg <= 4'd0;
      else if (md_start_E)
         md_cnt_reg <= md_op_E ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      else if (md_cnt_reg != 4'd0)
         md_cnt_reg <= md_cnt_reg - 4'd1;
   end

   assign md_busy = (md_cnt_reg != 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding selects, load-use/branch/MDU stalls.
// MDU tracking is built only when HAZARD_MDU_EN is defined.
module hazard_ctrl
   import hazard_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic       branch_D,
   input  logic       jr_D,
   input  logic [4:0] rs_E,
   input  logic [4:0] rt_E,
   input  logic [4:0] WriteReg_E,
   input  logic       RegWrite_E,
   input  logic [1:0] MemtoReg_E,
   input  logic [4:0] WriteReg_M,
   input  logic       RegWrite_M,
   input  logic [1:0] MemtoReg_M,
   input  logic [4:0] WriteReg_W,
   input  logic       RegWrite_W,
   input  logic       md_start_E,
   input  logic       md_op_E,
   input  logic       md_use_D,
   output logic       stall_F,
   output logic       stall_D,
   output logic       flush_E,
   output logic       md_busy,
   output logic [1:0] fwdA_D,
   output logic [1:0] fwdB_D,
   output logic [1:0] fwdA_E,
   output logic [1:0] fwdB_E
);

   logic lwstall;
   logic brstall;
   logic mdstall;
   logic any_stall;
   logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
   logic e_writes, m_loads;

`ifdef HAZARD_MDU_EN
   md_tracker u_md_tracker (
      .clk        (clk),
      .reset      (reset),
      .md_start_E (md_start_E),
      .md_op_E    (md_op_E),
      .md_busy    (md_busy)
   );
   assign mdstall = md_use_D && (md_busy || md_start_E);
`else
   logic unused_md;
   assign unused_md = ^{clk, md_start_E, md_op_E, md_use_D};
   assign md_busy   = 1'b0;
   assign mdstall   = 1'b0;
`endif

   assign e_writes = RegWrite_E && (WriteReg_E != 5'd0);
   assign m_loads  = RegWrite_M && (WriteReg_M != 5'd0) && (MemtoReg_M == MEMTO_LOAD);

   assign e_hit_rs = e_writes && (WriteReg_E == rs_D);
   assign e_hit_rt = e_writes && (WriteReg_E == rt_D);
   assign m_hit_rs = m_loads && (WriteReg_M == rs_D);
   assign m_hit_rt = m_loads && (WriteReg_M == rt_D);

   assign lwstall = (MemtoReg_E == MEMTO_LOAD) && (e_hit_rs || e_hit_rt);

   // The branch comparator sits in D, so even an ALU result still in EX is too late.
   assign brstall = (branch_D && (e_hit_rs || e_hit_rt || m_hit_rs || m_hit_rt))
                 || (jr_D && (e_hit_rs || m_hit_rs));

   assign any_stall = lwstall || brstall || mdstall;

   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      flush_E = 1'b1;
      fwdA_D  = FWD_RF;
      fwdB_D  = FWD_RF;
      fwdA_E  = FWD_RF;
      fwdB_E  = FWD_RF;
      if (!reset) begin
         stall_F = any_stall;
         stall_D = any_stall;
         flush_E = any_stall;
         fwdA_D  = fwd_select(rs_D, WriteReg_M, RegWrite_M, MemtoReg_M,
                              WriteReg_W, RegWrite_W, 1'b0);
         fwdB_D  = fwd_select(rt_D, WriteReg_M, RegWrite_M, MemtoReg_M,
                              WriteReg_W, RegWrite_W, 1'b0);
         fwdA_E  = fwd_select(rs_E, WriteReg_M, RegWrite_M, MemtoReg_M,
                              WriteReg_W, RegWrite_W, 1'b1);
         fwdB_E  = fwd_select(rt_E, WriteReg_M, RegWrite_M, MemtoReg_M,
                              WriteReg_W, RegWrite_W, 1'b1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs. a reference model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, rs_E, rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
   logic       branch_D, jr_D, RegWrite_E, RegWrite_M, RegWrite_W;
   logic [1:0] MemtoReg_E, MemtoReg_M;
   logic       md_start_E, md_op_E, md_use_D;
   logic       stall_F, stall_D, flush_E, md_busy;
   logic [1:0] fwdA_D, fwdB_D, fwdA_E, fwdB_E;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int busy_end = 0;
   logic model_on = 1'b0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .branch_D(branch_D), .jr_D(jr_D),
      .rs_E(rs_E), .rt_E(rt_E), .WriteReg_E(WriteReg_E), .RegWrite_E(RegWrite_E),
      .MemtoReg_E(MemtoReg_E), .WriteReg_M(WriteReg_M), .RegWrite_M(RegWrite_M),
      .MemtoReg_M(MemtoReg_M), .WriteReg_W(WriteReg_W), .RegWrite_W(RegWrite_W),
      .md_start_E(md_start_E), .md_op_E(md_op_E), .md_use_D(md_use_D),
      .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E), .md_busy(md_busy),
      .fwdA_D(fwdA_D), .fwdB_D(fwdB_D), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the MDU is busy for the N cycles following a start edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
`ifdef HAZARD_MDU_EN
      if (reset)
         busy_end <= cyc;
      else if (md_start_E)
         busy_end <= cyc + 1 + (md_op_E ? 10 : 5);
`endif
   end

   function automatic int ref_fwd(input logic [4:0] src, input bit allow_w);
      if (RegWrite_M && WriteReg_M != 0 && WriteReg_M == src)
         return (MemtoReg_M == 2'b10) ? 3 : 2;
      if (allow_w && RegWrite_W && WriteReg_W != 0 && WriteReg_W == src)
         return 1;
      return 0;
   endfunction

   // Does a pending producer write the given nonzero source register?
   function automatic bit ex_hits(input logic [4:0] src);
      return RegWrite_E && WriteReg_E != 0 && WriteReg_E == src;
   endfunction

   function automatic bit m_load_hits(input logic [4:0] src);
      return MemtoReg_M == 2'b01 && RegWrite_M && WriteReg_M != 0 && WriteReg_M == src;
   endfunction

   always @(negedge clk) begin
      if (model_on) begin
         bit m_busy, lw, br, md, stall;
         m_busy = (cyc < busy_end);
         lw = (MemtoReg_E == 2'b01) && (ex_hits(rs_D) || ex_hits(rt_D));
         br = (branch_D && (ex_hits(rs_D) || ex_hits(rt_D) || m_load_hits(rs_D) || m_load_hits(rt_D)))
           || (jr_D && (ex_hits(rs_D) || m_load_hits(rs_D)));
`ifdef HAZARD_MDU_EN
         md = md_use_D && (m_busy || md_start_E);
`else
         md = 1'b0;
`endif
         stall = !reset && (lw || br || md);
         chk("model_md_busy", int'(md_busy), int'(m_busy));
         chk("model_stall_F", int'(stall_F), int'(stall));
         chk("model_stall_D", int'(stall_D), int'(stall));
         chk("model_flush_E", int'(flush_E), int'(reset || stall));
         chk("model_fwdA_D", int'(fwdA_D), reset ? 0 : ref_fwd(rs_D, 1'b0));
         chk("model_fwdB_D", int'(fwdB_D), reset ? 0 : ref_fwd(rt_D, 1'b0));
         chk("model_fwdA_E", int'(fwdA_E), reset ? 0 : ref_fwd(rs_E, 1'b1));
         chk("model_fwdB_E", int'(fwdB_E), reset ? 0 : ref_fwd(rt_E, 1'b1));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rs_D = 0; rt_D = 0; branch_D = 0; jr_D = 0;
      rs_E = 0; rt_E = 0; WriteReg_E = 0; RegWrite_E = 0; MemtoReg_E = 0;
      WriteReg_M = 0; RegWrite_M = 0; MemtoReg_M = 0;
      WriteReg_W = 0; RegWrite_W = 0;
      md_start_E = 0; md_op_E = 0; md_use_D = 0;
   endtask

   initial begin
      int busy_cnt, stall_cnt;
      idle();
      reset = 1'b1;
      step();
      model_on = 1'b1;

      // Reset: flush high, stalls and forwards suppressed even with live hazards.
      RegWrite_M = 1; WriteReg_M = 7; rs_E = 7; MemtoReg_E = 2'b01; RegWrite_E = 1;
      WriteReg_E = 7; rs_D = 7;
      #1;
      chk("rst_flush_E", int'(flush_E), 1);
      chk("rst_stall_D", int'(stall_D), 0);
      chk("rst_fwdA_E", int'(fwdA_E), 0);
      step();
      reset = 1'b0; idle();
      #1;
      chk("idle_flush_E", int'(flush_E), 0);
      chk("idle_md_busy", int'(md_busy), 0);

      // Load-use: stall one cycle, then clear once the load is in M.
      RegWrite_E = 1; MemtoReg_E = 2'b01; WriteReg_E = 8; rs_D = 8;
      #1;
      chk("lw_stall_F", int'(stall_F), 1);
      chk("lw_flush_E", int'(flush_E), 1);
      step();
      RegWrite_E = 0; MemtoReg_E = 0; WriteReg_E = 0;
      RegWrite_M = 1; MemtoReg_M = 2'b01; WriteReg_M = 8;
      #1;
      chk("lw_after_stall_D", int'(stall_D), 0);
      step(); idle();

      // jal in M forwards pc8, even when W also writes r31.
      RegWrite_M = 1; WriteReg_M = 31; MemtoReg_M = 2'b10; rs_E = 31;
      #1;
      chk("pc8_fwdA_E", int'(fwdA_E), 3);
      RegWrite_W = 1; WriteReg_W = 31;
      #1;
      chk("pc8_over_w_fwdA_E", int'(fwdA_E), 3);
      RegWrite_M = 0;
      #1;
      chk("w_fwdA_E", int'(fwdA_E), 1);
      step(); idle();

      // Branch on a register still in EX, then forwarded from M.
      branch_D = 1; rt_D = 9; RegWrite_E = 1; WriteReg_E = 9;
      #1;
      chk("br_stall_D", int'(stall_D), 1);
      step();
      RegWrite_E = 0; WriteReg_E = 0; RegWrite_M = 1; WriteReg_M = 9; MemtoReg_M = 2'b00;
      #1;
      chk("br_fwdB_D", int'(fwdB_D), 2);
      chk("br_after_stall_D", int'(stall_D), 0);
      step(); idle();

      // Writes to r0 never forward and never hazard.
      RegWrite_M = 1; WriteReg_M = 0; rs_E = 0; RegWrite_E = 1; WriteReg_E = 0;
      branch_D = 1; MemtoReg_E = 2'b01;
      #1;
      chk("r0_fwdA_E", int'(fwdA_E), 0);
      chk("r0_stall_D", int'(stall_D), 0);
      step(); idle();

`ifdef HAZARD_MDU_EN
      // Divide: busy 10 cycles, stalled 11 with the consumer waiting in D.
      md_start_E = 1; md_op_E = 1; md_use_D = 1;
      #1;
      chk("div_start_stall_D", int'(stall_D), 1);
      step();
      md_start_E = 0;
      busy_cnt = 0; stall_cnt = 1;
      for (int i = 0; i < 14; i++) begin
         #1;
         busy_cnt += int'(md_busy);
         stall_cnt += int'(stall_D);
         step();
      end
      chk("div_busy_cycles", busy_cnt, 10);
      chk("div_stall_cycles", stall_cnt, 11);
      idle();

      // Reset on cycle 3 of a multiply abandons it.
      md_start_E = 1; md_op_E = 0;
      step();
      md_start_E = 0; md_use_D = 1;
      step();
      step();
      reset = 1;
      #1;
      chk("mult_rst_flush_E", int'(flush_E), 1);
      chk("mult_rst_stall_D", int'(stall_D), 0);
      step();
      reset = 0;
      #1;
      chk("mult_rst_md_busy", int'(md_busy), 0);
      chk("mult_rst_after_stall_D", int'(stall_D), 0);
      step(); idle();
`else
      md_start_E = 1; md_op_E = 1; md_use_D = 1;
      #1;
      chk("nomdu_stall_D", int'(stall_D), 0);
      step();
      #1;
      chk("nomdu_md_busy", int'(md_busy), 0);
      step(); idle();
`endif

      // Randomized traffic on a narrow register range to provoke hits.
      for (int i = 0; i < 800; i++) begin
         reset      = ($urandom_range(0, 49) == 0);
         rs_D       = 5'($urandom_range(0, 3));
         rt_D       = 5'($urandom_range(0, 3));
         branch_D   = ($urandom_range(0, 3) == 0);
         jr_D       = ($urandom_range(0, 5) == 0);
         rs_E       = 5'($urandom_range(0, 3));
         rt_E       = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         WriteReg_E = 5'($urandom_range(0, 3));
         RegWrite_E = 1'($urandom_range(0, 1));
         MemtoReg_E = 2'($urandom_range(0, 2));
         WriteReg_M = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         RegWrite_M = 1'($urandom_range(0, 1));
         MemtoReg_M = 2'($urandom_range(0, 2));
         WriteReg_W = 5'($urandom_range(0, 3));
         RegWrite_W = 1'($urandom_range(0, 1));
         md_start_E = ($urandom_range(0, 9) == 0);
         md_op_E    = 1'($urandom_range(0, 1));
         md_use_D   = ($urandom_range(0, 2) == 0);
         step();
      end

      model_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
